// File: rtl/stopwatch_core_pkg.sv
// Shared definitions for the stopwatch core: FSM state encoding and BCD digit limits.
package stopwatch_core_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2
    } sw_state_e;

    localparam int unsigned ONES_MAX = 9;
    localparam int unsigned TENS_MAX = 5;

endpackage

// File: rtl/stopwatch_core_bcd_digit.sv
// Modulo-(Max+1) counter digit with synchronous clear and a carry-out that
// fires when an increment rolls the digit over from Max to zero.
module bcd_digit
    import stopwatch_core_pkg::*;
#(
    parameter int unsigned Max   = ONES_MAX,
    parameter int unsigned Width = 4
) (
    input  logic             CLKIn,
    input  logic             Reset,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [Width-1:0] value_o,
    output logic             carry_o
);

    logic [Width-1:0] value_q;
    logic             at_max;

    assign at_max  = (value_q == Width'(Max));
    assign carry_o = inc_i & at_max;
    assign value_o = value_q;

    always_ff @(posedge CLKIn) begin
        if (Reset || clear_i) begin
            value_q <= '0;
        end else if (inc_i) begin
            value_q <= at_max ? '0 : value_q + Width'(1);
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch: edge-detects the 1 Hz tick, runs an IDLE/RUN/PAUSE control FSM
// and drives a chain of four BCD digits, pulsing Wrap on 59:59 -> 00:00.
module stopwatch_core
    import stopwatch_core_pkg::*;
(
    input  logic       CLKIn,
    input  logic       Reset,
    input  logic       TickIn,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Clear,
    output logic [3:0] SecOnes,
    output logic [2:0] SecTens,
    output logic [3:0] MinOnes,
    output logic [2:0] MinTens,
    output logic       Running,
    output logic       Wrap
);

    sw_state_e state_q;
    logic      running_q;
    logic      wrap_q;
    logic      tick_sync_q;
    logic      tick_prev_q;
    logic      tick_event;
    logic      count_en;
    logic      sec_ones_carry;
    logic      sec_tens_carry;
    logic      min_ones_carry;
    logic      min_tens_carry;

    assign tick_event = tick_sync_q & ~tick_prev_q;
    // Counting uses the current state, so a Start arriving with a tick does not count it.
    assign count_en   = tick_event & (state_q == StRun) & ~Clear & ~Stop;

    always_ff @(posedge CLKIn) begin
        if (Reset) begin
            tick_sync_q <= 1'b0;
            tick_prev_q <= 1'b0;
        end else begin
            tick_sync_q <= TickIn;
            tick_prev_q <= tick_sync_q;
        end
    end

    // Control FSM; priority Clear > Stop > Start.
    always_ff @(posedge CLKIn) begin
        if (Reset) begin
            state_q   <= StIdle;
            running_q <= 1'b0;
        end else if (Clear) begin
            state_q   <= StIdle;
            running_q <= 1'b0;
        end else if (Stop) begin
            if (state_q == StRun) begin
                state_q   <= StPause;
                running_q <= 1'b0;
            end
        end else if (Start) begin
            if (state_q != StRun) begin
                state_q   <= StRun;
                running_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLKIn) begin
        if (Reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= min_tens_carry;
        end
    end

    bcd_digit #(
        .Max   (ONES_MAX),
        .Width (4)
    ) u_sec_ones (
        .CLKIn   (CLKIn),
        .Reset   (Reset),
        .clear_i (Clear),
        .inc_i   (count_en),
        .value_o (SecOnes),
        .carry_o (sec_ones_carry)
    );

    bcd_digit #(
        .Max   (TENS_MAX),
        .Width (3)
    ) u_sec_tens (
        .CLKIn   (CLKIn),
        .Reset   (Reset),
        .clear_i (Clear),
        .inc_i   (sec_ones_carry),
        .value_o (SecTens),
        .carry_o (sec_tens_carry)
    );

    bcd_digit #(
        .Max   (ONES_MAX),
        .Width (4)
    ) u_min_ones (
        .CLKIn   (CLKIn),
        .Reset   (Reset),
        .clear_i (Clear),
        .inc_i   (sec_tens_carry),
        .value_o (MinOnes),
        .carry_o (min_ones_carry)
    );

    bcd_digit #(
        .Max   (TENS_MAX),
        .Width (3)
    ) u_min_tens (
        .CLKIn   (CLKIn),
        .Reset   (Reset),
        .clear_i (Clear),
        .inc_i   (min_ones_carry),
        .value_o (MinTens),
        .carry_o (min_tens_carry)
    );

    assign Running = running_q;
    assign Wrap    = wrap_q;

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 CLKIn  input  1  system clock, 50 MHz board clock; all state changes on its rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset.
REQ-003 TickIn  input  1  1 Hz square wave from the upstream frequency divider, generated in the CLKIn domain; each rising edge is one elapsed second.
REQ-004 Start  input  1  single-CLKIn-cycle pulse; run or resume the count.
REQ-005 Stop  input  1  single-CLKIn-cycle pulse; pause the count.
REQ-006 Clear  input  1  single-CLKIn-cycle pulse; zero the count and go idle.
REQ-007 SecOnes  output  4  BCD seconds units, 0-9.
REQ-008 SecTens  output  3  seconds tens, 0-5.
REQ-009 MinOnes  output  4  BCD minutes units, 0-9.
REQ-010 MinTens  output  3  minutes tens, 0-5.
REQ-011 Running  output  1  high while in the RUN state.
REQ-012 Wrap  output  1  one-cycle pulse on rollover from 59:59 to 00:00.

Function
REQ-013 The block SHALL register TickIn twice (TickSync, then TickPrev).
REQ-014 A tick event SHALL be the condition TickSync=1 and TickPrev=0.
REQ-015 Latency: the digits SHALL change on the CLKIn edge at which the tick event is true, i.e. 2 cycles after TickIn rises.
REQ-016 FSM states SHALL be IDLE, RUN and PAUSE.
REQ-017 Transitions: IDLE+Start->RUN; RUN+Stop->PAUSE; PAUSE+Start->RUN; any state+Clear->IDLE.
REQ-018 All other input combinations SHALL leave the state unchanged; Start in RUN and Stop in IDLE/PAUSE are no-ops.
REQ-019 Simultaneous control pulses: priority SHALL be Clear > Stop > Start.
REQ-020 Entering IDLE via Clear SHALL zero all four digits on the same edge.
REQ-021 A tick event SHALL increment the count only when the state is RUN and no Clear or Stop is present in that cycle.
REQ-022 A tick coinciding with Start in IDLE or PAUSE SHALL NOT increment.
REQ-023 Counting SHALL be a cascaded BCD increment:
  - SecOnes 9->0 carries into SecTens;
  - SecTens 5->0 carries into MinOnes;
  - MinOnes 9->0 carries into MinTens;
  - MinTens 5->0 is the full wrap.
REQ-024 At 59:59, a counted tick SHALL produce 00:00 and assert Wrap for exactly that one cycle; the state SHALL stay RUN.
REQ-025 Wrap SHALL be low in every cycle without a counted 59:59 rollover.
REQ-026 Digits SHALL never hold a value outside their stated range.
REQ-027 PAUSE SHALL hold the digits; a later Start SHALL continue from the held value.
REQ-028 Running SHALL be a registered decode of state==RUN, so it updates on the same edge as the state.

Reset
REQ-029 While Reset=1 at a CLKIn edge, the block SHALL clear state to IDLE, all digits to 0, Wrap to 0, Running to 0, and TickSync/TickPrev to 0.
REQ-030 Reset SHALL override Start, Stop, Clear and tick events in the same cycle.
REQ-031 Reset asserted mid-count SHALL take effect at the next CLKIn edge.
REQ-032 After Reset deasserts, no counting SHALL occur until a Start pulse is received.

Structure
REQ-033 A shared package SHALL hold:
  - the state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2);
  - digit limit constants (ONES_MAX=9, TENS_MAX=5).
REQ-034 One sub-module, bcd_digit, SHALL implement a modulo-(MAX+1) digit with inputs clear and inc, and a carry-out pulse.
REQ-035 stopwatch_core SHALL instantiate bcd_digit four times, chained by carry.

Verification
REQ-036 Reset, then Start, then 3 TickIn rising edges -> SecOnes=3; Running=1; each increment lands 2 cycles after the TickIn rise.
REQ-037 Count to 00:09, then 1 tick -> 00:10. Count to 00:59, then 1 tick -> 01:00.
REQ-038 Preload to 59:58 via ticks, then 2 ticks:
  - first tick -> 59:59;
  - second tick -> 00:00, with Wrap=1 for exactly 1 cycle and Running=1.
REQ-039 In RUN at 00:05:
  - Stop -> 2 ticks leave 00:05;
  - Start -> 1 tick gives 00:06.
REQ-040 Start, Stop and Clear in the same cycle while RUN at 00:07 -> IDLE and 00:00. A tick in the same cycle as Clear is not counted.
REQ-041 Reset asserted at 12:34 in RUN, in the same cycle as a tick and a Start -> 00:00, IDLE, Wrap=0. Later ticks without Start leave 00:00.
